// File: rtl/bus_mux_reg_if.sv
// Bus interface for bus_mux_reg: flattened source channels and enables in,
// registered bus value plus contention status out.
interface bus_mux_reg_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NSRC  = 24,
   parameter int unsigned CNT_W = 8
);
   localparam int unsigned SEL_W = $clog2(NSRC);

   logic [NSRC*WIDTH-1:0] src_data;
   logic [NSRC-1:0]       src_en;
   logic                  err_clr;
   logic [WIDTH-1:0]      bus_out;
   logic                  bus_valid;
   logic [SEL_W-1:0]      bus_sel;
   logic                  conflict;
   logic [CNT_W-1:0]      conflict_cnt;

   // Bus drivers and consumers.
   modport master (
      output src_data, src_en, err_clr,
      input  bus_out, bus_valid, bus_sel, conflict, conflict_cnt
   );

   // The multiplexer itself.
   modport slave (
      input  src_data, src_en, err_clr,
      output bus_out, bus_valid, bus_sel, conflict, conflict_cnt
   );
endinterface

// File: rtl/bus_mux_reg.sv
// Registered fixed-priority bus multiplexer with sticky contention detection
// and a saturating contention counter. All outputs come straight from flops.
module bus_mux_reg #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned NSRC      = 24,
   parameter int unsigned IDLE_HOLD = 1,
   parameter int unsigned CNT_W     = 8
) (
   input logic           clock,
   input logic           clear_n,
   bus_mux_reg_if.slave  bus
);
   localparam int unsigned SEL_W = $clog2(NSRC);

   logic [WIDTH-1:0] bus_out_q, bus_out_d;
   logic             bus_valid_q, bus_valid_d;
   logic [SEL_W-1:0] bus_sel_q, bus_sel_d;
   logic             conflict_q, conflict_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             win_hit;
   logic [SEL_W-1:0] win_idx;
   logic [WIDTH-1:0] win_data;
   logic             contention;

   // Lowest-index enabled channel wins; more than one enable bit is contention.
   always_comb begin
      win_hit  = 1'b0;
      win_idx  = '0;
      win_data = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (bus.src_en[i] && !win_hit) begin
            win_hit  = 1'b1;
            win_idx  = SEL_W'(i);
            win_data = bus.src_data[i*WIDTH +: WIDTH];
         end
      end
      // Clearing the lowest set bit leaves something only if two or more were set.
      contention = (bus.src_en & (bus.src_en - 1'b1)) != '0;
   end

   // Next-state for the bus register and the error bookkeeping.
   always_comb begin
      bus_out_d   = bus_out_q;
      bus_valid_d = 1'b0;
      bus_sel_d   = bus_sel_q;
      conflict_d  = conflict_q;
      cnt_d       = cnt_q;

      if (win_hit) begin
         bus_out_d   = win_data;
         bus_valid_d = 1'b1;
         bus_sel_d   = win_idx;
      end else if (IDLE_HOLD == 0) begin
         bus_out_d = '0;
      end

      // Contention outranks err_clr so a collision in the clear cycle is never lost.
      if (contention) begin
         conflict_d = 1'b1;
         if (bus.err_clr) begin
            cnt_d = CNT_W'(1);
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (bus.err_clr) begin
         conflict_d = 1'b0;
         cnt_d      = '0;
      end
   end

   // State register with asynchronous clear.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         bus_out_q   <= '0;
         bus_valid_q <= 1'b0;
         bus_sel_q   <= '0;
         conflict_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         bus_out_q   <= bus_out_d;
         bus_valid_q <= bus_valid_d;
         bus_sel_q   <= bus_sel_d;
         conflict_q  <= conflict_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.bus_out      = bus_out_q;
   assign bus.bus_valid    = bus_valid_q;
   assign bus.bus_sel      = bus_sel_q;
   assign bus.conflict     = conflict_q;
   assign bus.conflict_cnt = cnt_q;
endmodule
